// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types and default control-write addresses for the
// simulation-control monitor.
//   cause_e   : reason the run finished (NONE/STOP/TRAP/SIMLEN)
//   state_e   : monitor sequencing state (RUN/DRAIN/DONE)
//   *_ADDR    : default word addresses snooped on the data-memory write port
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_STOP   = 2'd1,
    CAUSE_TRAP   = 2'd2,
    CAUSE_SIMLEN = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned STOP_ADDR = 0;
  localparam int unsigned TRAP_ADDR = 8;
  localparam int unsigned DUMP_ADDR = 16;

endpackage

// File: rtl/sim_dump_fifo.sv
// sim_dump_fifo: first-word fall-through FIFO for register-dump entries.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and payload
//   pop_i             : remove head entry (ignored when empty)
//   rdata_o           : head entry, zero while empty
//   full_o, empty_o   : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module sim_dump_fifo #(
  parameter int Width = 32,
  parameter int Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic [Width-1:0]   mem_d [Depth];
  logic               pop_en;
  logic               push_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = wdata_i;
      wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sim_ctrl_monitor.sv
// sim_ctrl_monitor: snoops data-memory writes for stop / trap / register-dump
// control writes and sequences the run to completion.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   mem_*_i                 : snooped data-memory request
//   trap_stop_en_i          : trap write starts drain (1) or is only counted (0)
//   sim_len_i               : cycle limit, 0 = unlimited
//   dump_*                  : FWFT dump stream {idx, data}, valid/ready
//   dump_ovf_o              : sticky, a dump entry was dropped
//   trap_cnt_o, cycle_cnt_o : saturating counters
//   done_o, cause_o         : sticky completion flag and its reason
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal execution, control writes are acted on
// ST_DRAIN | stop/trap seen, counting down the drain window, writes ignored
// ST_DONE  | finished, terminal until reset; FIFO can still be drained
module sim_ctrl_monitor
  import sim_ctrl_pkg::*;
#(
  parameter int          AddrW       = 15,
  parameter int          DataW       = 32,
  parameter int unsigned StopAddr    = STOP_ADDR,
  parameter int unsigned TrapAddr    = TRAP_ADDR,
  parameter int unsigned DumpAddr    = DUMP_ADDR,
  parameter int          DrainCycles = 50,
  parameter int          NumRegs     = 31,
  parameter int          DumpDepth   = 8,
  parameter int          CycW        = 32,
  localparam int         IdxW        = $clog2(NumRegs + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_req_i,
  input  logic             mem_we_i,
  input  logic [AddrW-1:0] mem_addr_i,
  input  logic [DataW-1:0] mem_wdata_i,
  input  logic             trap_stop_en_i,
  input  logic [CycW-1:0]  sim_len_i,
  output logic             dump_valid_o,
  input  logic             dump_ready_i,
  output logic [IdxW-1:0]  dump_idx_o,
  output logic [DataW-1:0] dump_data_o,
  output logic             dump_ovf_o,
  output logic [7:0]       trap_cnt_o,
  output logic [CycW-1:0]  cycle_cnt_o,
  output logic             done_o,
  output logic [1:0]       cause_o
);

  localparam int DrnW = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [DrnW-1:0]   drain_q, drain_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [7:0]        trap_q, trap_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              ovf_q, ovf_d;

  logic              wr_en, stop_wr, trap_wr, dump_wr;
  logic              limit_hit, dump_push, dump_pop;
  logic              fifo_full, fifo_empty;

  assign wr_en   = mem_req_i & mem_we_i;
  assign stop_wr = wr_en && (mem_addr_i == AddrW'(StopAddr));
  assign trap_wr = wr_en && (mem_addr_i == AddrW'(TrapAddr));
  assign dump_wr = wr_en && (mem_addr_i == AddrW'(DumpAddr));

  assign limit_hit = (sim_len_i != '0) && (cyc_q == sim_len_i - CycW'(1));

  assign dump_push = (state_q == ST_RUN) && dump_wr;
  assign dump_pop  = dump_valid_o & dump_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic; the cycle limit outranks a same-cycle stop/trap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (limit_hit)                         state_d = ST_DONE;
        else if (stop_wr)                      state_d = ST_DRAIN;
        else if (trap_wr && trap_stop_en_i)    state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (limit_hit || (drain_q == '0))      state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    done_o      = (state_q == ST_DONE);
    cause_o     = cause_q;
    trap_cnt_o  = trap_q;
    cycle_cnt_o = cyc_q;
    dump_ovf_o  = ovf_q;
  end

  // Counters, cause and dump bookkeeping
  always_comb begin
    cause_d = cause_q;
    drain_d = drain_q;
    cyc_d   = cyc_q;
    trap_d  = trap_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    if ((state_q != ST_DONE) && (cyc_q != '1)) cyc_d = cyc_q + CycW'(1);

    if (state_q == ST_RUN) begin
      if (limit_hit) begin
        cause_d = CAUSE_SIMLEN;
      end else if (stop_wr) begin
        cause_d = CAUSE_STOP;
        drain_d = DrnW'(DrainCycles);
      end else if (trap_wr) begin
        if (trap_stop_en_i) begin
          cause_d = CAUSE_TRAP;
          drain_d = DrnW'(DrainCycles);
        end else if (trap_q != 8'hFF) begin
          trap_d = trap_q + 8'd1;
        end
      end

      // Index advances on every dump write, even a dropped one.
      if (dump_wr) begin
        idx_d = (idx_q == IdxW'(NumRegs)) ? IdxW'(1) : idx_q + IdxW'(1);
        if (fifo_full && !dump_pop) ovf_d = 1'b1;
      end
    end else if (state_q == ST_DRAIN) begin
      if (drain_q != '0) drain_d = drain_q - DrnW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_q <= CAUSE_NONE;
      drain_q <= '0;
      cyc_q   <= '0;
      trap_q  <= '0;
      idx_q   <= IdxW'(1);
      ovf_q   <= 1'b0;
    end else begin
      cause_q <= cause_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
      trap_q  <= trap_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  sim_dump_fifo #(
    .Width(IdxW + DataW),
    .Depth(DumpDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (dump_push),
    .wdata_i ({idx_q, mem_wdata_i}),
    .pop_i   (dump_pop),
    .rdata_o ({dump_idx_o, dump_data_o}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dump_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// tb_sim_ctrl_monitor: directed stimulus with a dump-stream scoreboard.
module tb_sim_ctrl_monitor;
  import sim_ctrl_pkg::*;

  localparam int AddrW = 15;
  localparam int DataW = 32;
  localparam int CycW  = 32;
  localparam int IdxW  = 5;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             mem_req_i = 1'b0;
  logic             mem_we_i = 1'b0;
  logic [AddrW-1:0] mem_addr_i = '0;
  logic [DataW-1:0] mem_wdata_i = '0;
  logic             trap_stop_en_i = 1'b0;
  logic [CycW-1:0]  sim_len_i = '0;
  logic             dump_valid_o;
  logic             dump_ready_i = 1'b0;
  logic [IdxW-1:0]  dump_idx_o;
  logic [DataW-1:0] dump_data_o;
  logic             dump_ovf_o;
  logic [7:0]       trap_cnt_o;
  logic [CycW-1:0]  cycle_cnt_o;
  logic             done_o;
  logic [1:0]       cause_o;

  always #5 clk = ~clk;

  sim_ctrl_monitor dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .trap_stop_en_i (trap_stop_en_i),
    .sim_len_i      (sim_len_i),
    .dump_valid_o   (dump_valid_o),
    .dump_ready_i   (dump_ready_i),
    .dump_idx_o     (dump_idx_o),
    .dump_data_o    (dump_data_o),
    .dump_ovf_o     (dump_ovf_o),
    .trap_cnt_o     (trap_cnt_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .done_o         (done_o),
    .cause_o        (cause_o)
  );

  typedef struct packed {
    logic [IdxW-1:0]  idx;
    logic [DataW-1:0] data;
  } dump_t;

  dump_t exp_q[$];
  dump_t exp_e;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake on the dump stream must match the
  // oldest expected entry.
  always @(negedge clk) begin
    if (!rst_i && dump_valid_o && dump_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dump_unexpected: got idx %0d data 0x%0h expected no entry",
                 dump_idx_o, dump_data_o);
      end else begin
        exp_e = exp_q.pop_front();
        chk("dump_idx", 64'(dump_idx_o), 64'(exp_e.idx));
        chk("dump_data", 64'(dump_data_o), 64'(exp_e.data));
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int unsigned addr, input logic [DataW-1:0] d);
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = AddrW'(addr);
    mem_wdata_i = d;
    tick_n(1);
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
  endtask

  task automatic dump(input logic [DataW-1:0] d, input int idx, input bit accept);
    if (accept) exp_q.push_back({IdxW'(idx), d});
    wr(DUMP_ADDR, d);
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    tick_n(1);
    exp_q.delete();
    rst_i = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(dump_valid_o), 0);
    chk({tag, "_ovf"},   64'(dump_ovf_o),   0);
    chk({tag, "_trap"},  64'(trap_cnt_o),   0);
    chk({tag, "_cycle"}, 64'(cycle_cnt_o),  0);
    chk({tag, "_done"},  64'(done_o),       0);
    chk({tag, "_cause"}, 64'(cause_o),      0);
  endtask

  // done_o must stay low for n-1 edges and be high after edge n.
  task automatic wait_done(input string tag, input int n);
    tick_n(n - 1);
    chk({tag, "_done_early"}, 64'(done_o), 0);
    tick_n(1);
    chk({tag, "_done_late"}, 64'(done_o), 1);
  endtask

  initial begin
    // Stop sequence
    do_reset();
    chk_idle("reset");
    dump_ready_i = 1'b1;
    dump(32'hA, 1, 1'b1);
    dump(32'hB, 2, 1'b1);
    dump(32'hC, 3, 1'b1);
    tick_n(16);
    chk("cyc_pre_stop", 64'(cycle_cnt_o), 19);
    wr(STOP_ADDR, '0);
    chk("stop_cause", 64'(cause_o), 1);
    chk("stop_drain_done", 64'(done_o), 0);
    wait_done("stop", 51);
    chk("stop_cause_done", 64'(cause_o), 1);
    chk("stop_sb_empty", 64'(exp_q.size()), 0);
    dump(32'hDD, 4, 1'b0);
    tick_n(2);
    chk("done_dump_ignored", 64'(dump_valid_o), 0);
    dump_ready_i = 1'b0;

    // Trap: counted, then stopping
    do_reset();
    trap_stop_en_i = 1'b0;
    wr(TRAP_ADDR, 32'h1);
    chk("trap_cnt1", 64'(trap_cnt_o), 1);
    chk("trap_nostop_cause", 64'(cause_o), 0);
    wr(TRAP_ADDR, 32'h1);
    chk("trap_cnt2", 64'(trap_cnt_o), 2);
    trap_stop_en_i = 1'b1;
    wr(TRAP_ADDR, 32'h1);
    chk("trap_cause", 64'(cause_o), 2);
    chk("trap_cnt_hold", 64'(trap_cnt_o), 2);
    wait_done("trap", 51);
    trap_stop_en_i = 1'b0;

    // Cycle limit
    sim_len_i = 32'd100;
    do_reset();
    tick_n(99);
    chk("lim_cyc99", 64'(cycle_cnt_o), 99);
    chk("lim_done99", 64'(done_o), 0);
    tick_n(1);
    chk("lim_done", 64'(done_o), 1);
    chk("lim_cyc100", 64'(cycle_cnt_o), 100);
    chk("lim_cause", 64'(cause_o), 3);
    tick_n(5);
    chk("lim_cyc_frozen", 64'(cycle_cnt_o), 100);
    do_reset();
    tick_n(99);
    wr(STOP_ADDR, '0);
    chk("lim_vs_stop_cause", 64'(cause_o), 3);
    chk("lim_vs_stop_done", 64'(done_o), 1);
    sim_len_i = '0;

    // FIFO overflow and index continuation
    do_reset();
    dump_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) dump(32'h100 + i, i + 1, i < 8);
    chk("ovf_set", 64'(dump_ovf_o), 1);
    chk("ovf_valid", 64'(dump_valid_o), 1);
    chk("ovf_head_idx", 64'(dump_idx_o), 1);
    dump_ready_i = 1'b1;
    tick_n(8);
    dump_ready_i = 1'b0;
    chk("ovf_drained", 64'(dump_valid_o), 0);
    dump(32'h200, 11, 1'b1);
    chk("ovf_next_idx", 64'(dump_idx_o), 11);
    dump_ready_i = 1'b1;
    tick_n(1);
    dump_ready_i = 1'b0;

    // Push and pop on the same full cycle
    do_reset();
    for (int i = 0; i < 8; i++) dump(32'h300 + i, i + 1, 1'b1);
    chk("full_no_ovf", 64'(dump_ovf_o), 0);
    dump_ready_i = 1'b1;
    dump(32'h308, 9, 1'b1);
    dump_ready_i = 1'b0;
    chk("pushpop_no_ovf", 64'(dump_ovf_o), 0);
    chk("pushpop_head", 64'(dump_idx_o), 2);
    dump_ready_i = 1'b1;
    tick_n(8);
    dump_ready_i = 1'b0;
    chk("pushpop_empty", 64'(dump_valid_o), 0);
    chk("pushpop_sb_empty", 64'(exp_q.size()), 0);

    // Index wrap
    do_reset();
    dump_ready_i = 1'b1;
    for (int i = 0; i < 33; i++) dump(32'h400 + i, (i % 31) + 1, 1'b1);
    tick_n(2);
    chk("wrap_sb_empty", 64'(exp_q.size()), 0);
    dump_ready_i = 1'b0;

    // Reset in the middle of a drain with the FIFO occupied
    do_reset();
    dump(32'h55, 1, 1'b1);
    wr(STOP_ADDR, '0);
    tick_n(10);
    chk("mid_cause", 64'(cause_o), 1);
    chk("mid_valid", 64'(dump_valid_o), 1);
    do_reset();
    chk_idle("mid_reset");
    wr(STOP_ADDR, '0);
    wait_done("mid", 51);
    chk("mid_cause_done", 64'(cause_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
